// File: rtl/sonar_buf_pkg.sv
// rtl/sonar_buf_pkg.sv - shared constants, register map and FSM encoding for sonar_buf_arb
// Purpose: register offsets, CTRL/STATUS bit positions, arbiter state enum and
//          buffer-window size helper used by the top and the register block.
package sonar_buf_pkg;

    // The block claims an 8 KiB slice of Wishbone space: buffer window at the
    // bottom, CTRL/STATUS at 0x1000, everything else acks with zero data.
    localparam int BLK_BITS = 13;

    localparam logic [BLK_BITS-1:0] CTRL_OFF   = 13'h1000;
    localparam logic [BLK_BITS-1:0] STATUS_OFF = 13'h1004;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;
    localparam int CTRL_ACK_BIT = 2;

    localparam int STAT_WRAP_BIT  = 16;
    localparam int STAT_FRAME_LSB = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MEM_RD = 2'd1,
        ST_ACK    = 2'd2
    } arb_state_e;

    // Buffer window size in bytes for a 2^aw-word buffer of 32-bit words.
    function automatic int win_bytes(input int aw);
        return 4 << aw;
    endfunction

endpackage

// File: rtl/sonar_buf_arb_if.sv
// rtl/sonar_buf_arb_if.sv - Wishbone slave bundle between the SoC and sonar_buf_arb
// Ports: cyc/stb/we/sel/adr/dat_i from the host, ack/dat_o back to it.
interface sonar_buf_arb_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/sonar_buf_regs.sv
// rtl/sonar_buf_regs.sv - capture enable, write pointer, frame counter and wrap flag
// Ports: clk/rst_n; ctrl_wr + ctrl_bits (CTRL write strobe and its low 3 bits);
//        inc (a stream write is issued this cycle); enable_o, wr_ptr_o,
//        frame_cnt_o, wrap_flag_o (register state).
module sonar_buf_regs
    import sonar_buf_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ctrl_wr,
    input  logic [2:0]    ctrl_bits,
    input  logic          inc,
    output logic          enable_o,
    output logic [AW-1:0] wr_ptr_o,
    output logic [7:0]    frame_cnt_o,
    output logic          wrap_flag_o
);

    logic          enable_q, enable_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [7:0]    frame_q, frame_d;
    logic          wrap_q, wrap_d;
    logic          clr, irq_ack, wrap_evt;

    always_comb begin
        clr      = ctrl_wr & ctrl_bits[CTRL_CLR_BIT];
        irq_ack  = ctrl_wr & ctrl_bits[CTRL_ACK_BIT];
        wrap_evt = inc & (wr_ptr_q == '1);

        enable_d = ctrl_wr ? ctrl_bits[CTRL_EN_BIT] : enable_q;

        // Clear beats a same-cycle increment; the write itself already used
        // the old pointer as its address.
        wr_ptr_d = wr_ptr_q;
        frame_d  = frame_q;
        if (clr) begin
            wr_ptr_d = '0;
            frame_d  = '0;
        end else if (inc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (wrap_evt) begin
                frame_d = frame_q + 8'd1;
            end
        end

        // A wrap landing with the acknowledge keeps the flag set so it is not lost.
        if (wrap_evt) begin
            wrap_d = 1'b1;
        end else if (irq_ack) begin
            wrap_d = 1'b0;
        end else begin
            wrap_d = wrap_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= 1'b0;
            wr_ptr_q <= '0;
            frame_q  <= '0;
            wrap_q   <= 1'b0;
        end else begin
            enable_q <= enable_d;
            wr_ptr_q <= wr_ptr_d;
            frame_q  <= frame_d;
            wrap_q   <= wrap_d;
        end
    end

    assign enable_o    = enable_q;
    assign wr_ptr_o    = wr_ptr_q;
    assign frame_cnt_o = frame_q;
    assign wrap_flag_o = wrap_q;

endmodule

// File: rtl/sonar_buf_arb.sv
// rtl/sonar_buf_arb.sv - single-port sample-buffer arbiter between DSP stream and Wishbone host
// Ports: wb_clk_i/wb_rst_n; wbs (Wishbone slave bundle); s_valid_i/s_data_i/s_ready_o
//        (stream); mem_* (SRAM macro, read data one cycle after enable); irq_o (wrap).
module sonar_buf_arb
    import sonar_buf_pkg::*;
#(
    parameter int          AW         = 10,
    parameter int          DW         = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          STARVE_MAX = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    sonar_buf_arb_if.slave    wbs,
    input  logic              s_valid_i,
    input  logic [DW-1:0]     s_data_i,
    output logic              s_ready_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [DW-1:0]     mem_wdata_o,
    output logic [3:0]        mem_wmask_o,
    input  logic [DW-1:0]     mem_rdata_i,
    output logic              irq_o
);

    localparam logic [31:0] WIN_BYTES  = 32'(win_bytes(AW));
    localparam int          SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arb_state_e    state_q, state_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [SW-1:0] starve_q, starve_d;

    logic                enable, wrap_flag;
    logic [AW-1:0]       wr_ptr;
    logic [7:0]          frame_cnt;
    logic [BLK_BITS-1:0] off;
    logic                hit, is_buf, host_req, host_buf_req, host_reg_req;
    logic                host_grant, stream_go, ctrl_wr;
    logic [31:0]         reg_rdata;
    logic [1:0]          unused_adr_bits;

    assign unused_adr_bits = wbs.wbs_adr_i[1:0];

    // Decode and arbitration. Requests are only looked at in IDLE, so the ack
    // cycle cannot start a second transfer. Gating with the reset pin keeps the
    // SRAM quiet the moment reset asserts.
    always_comb begin
        off          = wbs.wbs_adr_i[BLK_BITS-1:0];
        hit          = (wbs.wbs_adr_i[31:BLK_BITS] == BASE_ADDR[31:BLK_BITS]);
        is_buf       = ({{(32-BLK_BITS){1'b0}}, off} < WIN_BYTES);
        host_req     = wb_rst_n & wbs.wbs_cyc_i & wbs.wbs_stb_i & hit & (state_q == ST_IDLE);
        host_buf_req = host_req & is_buf;
        host_reg_req = host_req & ~is_buf;
        stream_go    = wb_rst_n & enable & s_valid_i &
                       (~host_buf_req | (starve_q < STARVE_LIM));
        host_grant   = host_buf_req & ~stream_go;
        ctrl_wr      = host_reg_req & wbs.wbs_we_i & (off == CTRL_OFF) & wbs.wbs_sel_i[0];

        reg_rdata = '0;
        if (off == CTRL_OFF) begin
            reg_rdata[CTRL_EN_BIT] = enable;
        end else if (off == STATUS_OFF) begin
            reg_rdata[AW-1:0]                = wr_ptr;
            reg_rdata[STAT_WRAP_BIT]         = wrap_flag;
            reg_rdata[STAT_FRAME_LSB +: 8]   = frame_cnt;
        end
    end

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q  <= ST_IDLE;
            dat_q    <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            dat_q    <= dat_d;
            starve_q <= starve_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (host_grant) begin
                    state_d = wbs.wbs_we_i ? ST_ACK : ST_MEM_RD;
                end else if (host_reg_req) begin
                    state_d = ST_ACK;
                end
            end
            ST_MEM_RD: state_d = ST_ACK;
            default:   state_d = ST_IDLE;
        endcase

        // Register reads are captured at request time; buffer reads one cycle
        // after the grant when the macro's data is valid.
        dat_d = dat_q;
        if (host_reg_req) begin
            dat_d = wbs.wbs_we_i ? '0 : reg_rdata;
        end else if (host_grant) begin
            dat_d = '0;
        end else if (state_q == ST_MEM_RD) begin
            dat_d = mem_rdata_i;
        end

        // Counts stream wins against a waiting host; once it hits the limit the
        // host takes the next slot.
        if (host_grant || !host_buf_req) begin
            starve_d = '0;
        end else if (stream_go && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Output logic.
    always_comb begin
        wbs.wbs_ack_o = (state_q == ST_ACK);
        wbs.wbs_dat_o = (state_q == ST_ACK) ? dat_q : '0;
        s_ready_o     = stream_go;
        mem_en_o      = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        mem_wmask_o   = '0;
        if (stream_go) begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = wr_ptr;
            mem_wdata_o = s_data_i;
            mem_wmask_o = 4'hF;
        end else if (host_grant) begin
            mem_en_o    = 1'b1;
            mem_we_o    = wbs.wbs_we_i;
            mem_addr_o  = wbs.wbs_adr_i[AW+1:2];
            mem_wdata_o = wbs.wbs_dat_i;
            mem_wmask_o = wbs.wbs_we_i ? wbs.wbs_sel_i : 4'h0;
        end
    end

    sonar_buf_regs #(.AW(AW)) u_regs (
        .clk         (wb_clk_i),
        .rst_n       (wb_rst_n),
        .ctrl_wr     (ctrl_wr),
        .ctrl_bits   (wbs.wbs_dat_i[2:0]),
        .inc         (stream_go),
        .enable_o    (enable),
        .wr_ptr_o    (wr_ptr),
        .frame_cnt_o (frame_cnt),
        .wrap_flag_o (wrap_flag)
    );

    assign irq_o = wrap_flag;

endmodule

// File: tb/tb_sonar_buf_arb.sv
// tb/tb_sonar_buf_arb.sv - self-checking bench for sonar_buf_arb
module tb_sonar_buf_arb;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] CTRL = BASE + 32'h1000;
    localparam logic [31:0] STAT = BASE + 32'h1004;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid_i;
    logic [31:0] s_data_i;
    logic        s_ready_o;
    logic        mem_en_o, mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic [31:0] mem_rdata_i = '0;
    logic        irq_o;

    sonar_buf_arb_if wb ();

    sonar_buf_arb #(.AW(10), .DW(32), .BASE_ADDR(BASE), .STARVE_MAX(4)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n    (rst_n),
        .wbs         (wb),
        .s_valid_i   (s_valid_i),
        .s_data_i    (s_data_i),
        .s_ready_o   (s_ready_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wmask_o (mem_wmask_o),
        .mem_rdata_i (mem_rdata_i),
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;

    // Behavioural model of the single-port SRAM macro.
    logic [31:0] sram [0:1023];
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wmask_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                end
            end else begin
                mem_rdata_i <= sram[mem_addr_o];
            end
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    logic [31:0] st_q[$];
    logic [31:0] rd_q[$];
    logic [9:0]  exp_wptr = '0;
    int          st_seq   = 0;
    logic        pend_clr = 1'b0;
    logic        last_ready, last_en, last_ack, last_irq;
    logic [31:0] last_dat;
    logic [3:0]  last_mask;
    int          g_cyc, a_cyc, start_c, lat, st_before;
    logic        st_after;
    logic [3:0]  g_mask;
    logic [31:0] rdata;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wd;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t vt[8];

    function automatic logic [31:0] mk(input int k);
        return 32'hA000_0000 | 32'(k);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // One clock: sample at negedge (stream scoreboard), return at posedge+1.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        cyc_n++;
        last_ready = s_ready_o;
        last_en    = mem_en_o;
        last_ack   = wb.wbs_ack_o;
        last_dat   = wb.wbs_dat_o;
        last_mask  = mem_wmask_o;
        last_irq   = irq_o;
        if (s_ready_o) begin
            chk("st_addr", 32'(mem_addr_o), 32'(exp_wptr));
            chk("st_we_mask", {27'b0, mem_we_o, mem_wmask_o}, 32'h1F);
            if (st_q.size() == 0) chk("st_queue", 32'(st_q.size()), 32'd1);
            else begin
                e = st_q.pop_front();
                chk("st_data", mem_wdata_o, e);
            end
            exp_wptr = exp_wptr + 10'd1;
            st_seq++;
        end
        if (pend_clr) begin
            exp_wptr = '0;
            pend_clr = 1'b0;
        end
        @(posedge clk);
        #1;
        if (last_ready) begin
            s_data_i = mk(st_seq);
            st_q.push_back(s_data_i);
        end
    endtask

    task automatic wb_go(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] d, input int max_cyc);
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
        wb.wbs_adr_i = adr;  wb.wbs_sel_i = sel;  wb.wbs_dat_i = d;
        start_c = cyc_n + 1; g_cyc = -1; a_cyc = -1; st_before = 0; st_after = 1'b0; g_mask = '0;
        for (int i = 0; i < max_cyc && a_cyc < 0; i++) begin
            tick();
            if (g_cyc >= 0 && cyc_n == g_cyc + 1) st_after = last_ready;
            if (last_en && !last_ready && g_cyc < 0) begin
                g_cyc  = cyc_n;
                g_mask = last_mask;
            end else if (g_cyc < 0 && last_ready) begin
                st_before++;
            end
            if (last_ack) begin
                a_cyc = cyc_n;
                rdata = last_dat;
            end
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        lat = (a_cyc < 0) ? -1 : a_cyc - start_c;
    endtask

    task automatic host(input string nm, input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] d, input logic [31:0] exp, input int exp_lat);
        logic [31:0] e;
        if (!we) rd_q.push_back(exp);
        wb_go(we, adr, sel, d, 40);
        chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
        if (!we) begin
            e = rd_q.pop_front();
            if (a_cyc >= 0) chk({nm, "_dat"}, rdata, e);
        end
    endtask

    initial begin
        logic any_ack;
        rst_n = 1'b0; s_valid_i = 1'b0; s_data_i = mk(0); st_q.push_back(mk(0));
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = '0; wb.wbs_adr_i = '0; wb.wbs_dat_i = '0;

        vt[0] = '{1'b0, CTRL,                 4'hF, 32'h0,        32'h1,        1};
        vt[1] = '{1'b1, BASE + 32'h1008,      4'hF, 32'hDEAD,     32'h0,        1};
        vt[2] = '{1'b0, BASE + 32'h1008,      4'hF, 32'h0,        32'h0,        1};
        vt[3] = '{1'b0, BASE + 32'h1FFC,      4'hF, 32'h0,        32'h0,        1};
        vt[4] = '{1'b1, BASE + 32'h50,        4'hF, 32'hCAFEF00D, 32'h0,        1};
        vt[5] = '{1'b1, BASE + 32'h50,        4'hC, 32'h12345678, 32'h0,        1};
        vt[6] = '{1'b0, BASE + 32'h50,        4'hF, 32'h0,        32'h1234F00D, 2};
        vt[7] = '{1'b0, BASE + 32'h8,         4'hF, 32'h0,        mk(2),        2};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {27'b0, wb.wbs_ack_o, s_ready_o, mem_en_o, mem_we_o, irq_o}, 32'h0);
        chk("rst_dat", wb.wbs_dat_o, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        host("enable", 1'b1, CTRL, 4'hF, 32'h1, 32'h0, 1);

        // Three samples back-to-back, addresses 0..2 checked by the scoreboard.
        begin
            int n = 0;
            s_valid_i = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (last_ready) n++;
            end
            s_valid_i = 1'b0;
            chk("s1_ready_cnt", 32'(n), 32'd3);
        end
        host("s1_status", 1'b0, STAT, 4'hF, 32'h0, 32'h0000_0003, 1);

        host("s2_rd1", 1'b0, BASE + 32'h4, 4'hF, 32'h0, mk(1), 2);
        chk("s2_grant_at_req", 32'(g_cyc - start_c), 32'd0);

        for (int i = 0; i < 8; i++) begin
            host($sformatf("vec%0d", i), vt[i].we, vt[i].adr, vt[i].sel, vt[i].wd, vt[i].exp, vt[i].lat);
        end

        wb_go(1'b0, BASE + 32'h2000, 4'hF, 32'h0, 6);
        chk("outside_noack", 32'(a_cyc), 32'hFFFF_FFFF);

        // Starvation limit: 4 stream grants, one host slot, then streaming again.
        s_valid_i = 1'b1;
        tick(); tick();
        host("s3_rd0", 1'b0, BASE, 4'hF, 32'h0, mk(0), 6);
        s_valid_i = 1'b0;
        chk("s3_stream_before", 32'(st_before), 32'd4);
        chk("s3_resume", {31'b0, st_after}, 32'd1);
        chk("s3_grant_to_ack", 32'(a_cyc - g_cyc), 32'd2);

        // Full wrap: 1025 samples from a cleared pointer.
        pend_clr = 1'b1;
        host("clr", 1'b1, CTRL, 4'hF, 32'h3, 32'h0, 1);
        begin
            int n = 0;
            s_valid_i = 1'b1;
            for (int i = 0; i < 1200 && n < 1025; i++) begin
                tick();
                if (last_ready) n++;
            end
            s_valid_i = 1'b0;
            chk("wrap_cnt", 32'(n), 32'd1025);
        end
        host("wrap_status", 1'b0, STAT, 4'hF, 32'h0, 32'h0101_0001, 1);
        chk("wrap_irq", {31'b0, last_irq}, 32'd1);
        host("irq_ack", 1'b1, CTRL, 4'hF, 32'h5, 32'h0, 1);
        chk("irq_cleared", {31'b0, last_irq}, 32'd0);
        host("ack_status", 1'b0, STAT, 4'hF, 32'h0, 32'h0100_0001, 1);

        // Acknowledge in the same cycle as the wrapping write.
        s_valid_i = 1'b1;
        for (int i = 0; i < 1100 && exp_wptr != 10'h3FF; i++) tick();
        host("ack_on_wrap", 1'b1, CTRL, 4'hF, 32'h5, 32'h0, 1);
        s_valid_i = 1'b0;
        chk("irq_wrap_wins", {31'b0, last_irq}, 32'd1);
        host("wrap2_status", 1'b0, STAT, 4'hF, 32'h0, 32'h0201_0001, 1);

        // clr_ptr with a stream write at pointer 5.
        s_valid_i = 1'b1;
        for (int i = 0; i < 20 && exp_wptr != 10'd5; i++) tick();
        pend_clr = 1'b1;
        host("clr_at5", 1'b1, CTRL, 4'hF, 32'h3, 32'h0, 1);
        s_valid_i = 1'b0;
        host("clr_status", 1'b0, STAT, 4'hF, 32'h0, 32'h0001_0001, 1);

        // Reset while in MEM_RD.
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
        wb.wbs_adr_i = BASE + 32'hC; wb.wbs_sel_i = 4'hF;
        tick();
        chk("s6_grant", {31'b0, last_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_outs", {27'b0, wb.wbs_ack_o, s_ready_o, mem_en_o, mem_we_o, irq_o}, 32'h0);
        chk("s6_rst_dat", wb.wbs_dat_o, 32'h0);
        any_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            any_ack = any_ack | last_ack;
        end
        chk("s6_no_ack", {31'b0, any_ack}, 32'd0);
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
        rst_n = 1'b1;
        exp_wptr = '0;
        tick();
        host("s6_wr_full", 1'b1, BASE + 32'h1C, 4'hF, 32'hAABBCCDD, 32'h0, 1);
        host("s6_wr_part", 1'b1, BASE + 32'h1C, 4'h3, 32'h12345678, 32'h0, 1);
        chk("s6_mask", {28'b0, g_mask}, 32'h3);
        chk("s6_grant_to_ack", 32'(a_cyc - g_cyc), 32'd1);
        host("s6_rd", 1'b0, BASE + 32'h1C, 4'hF, 32'h0, 32'hAABB5678, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sonar_buf_arb.md
Name: sonar_buf_arb

Overview:
Arbitrates a single-port sample-buffer SRAM macro between two requesters: the sonar DSP write stream and the management-SoC Wishbone slave port. The stream fills the buffer as a circular capture buffer. The host reads captured samples, and may write them, through the Wishbone data window. A small control/status register pair lets firmware enable capture, clear the pointer and acknowledge wrap interrupts. The block sits between the user-project Wishbone slave interface and the buffer macro.

Parameters:
AW, 10, buffer address width; depth is 2^AW words.
DW, 32, data width. Fixed at 32 for Wishbone compatibility.
BASE_ADDR, 32'h3000_0000, Wishbone base address of the block.
STARVE_MAX, 4, maximum consecutive stream grants while a host buffer access is pending.

Ports:
wb_clk_i  in  1  single clock for the block
wb_rst_n  in  1  asynchronous, active-low reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  Wishbone write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge, one-cycle pulse
wbs_dat_o  out  32  read data
s_valid_i  in  1  stream sample valid
s_data_i  in  DW  stream sample
s_ready_o  out  1  stream accepted this cycle
mem_en_o  out  1  SRAM enable
mem_we_o  out  1  SRAM write enable
mem_addr_o  out  AW  SRAM word address
mem_wdata_o  out  DW  SRAM write data
mem_wmask_o  out  4  SRAM byte mask
mem_rdata_i  in  DW  SRAM read data, valid 1 cycle after a read enable
irq_o  out  1  sticky wrap interrupt

Behaviour:
- Reset (async assert, sync release): all outputs 0; wr_ptr=0, frame_cnt=0, enable=0, wrap_flag=0, starve_cnt=0; FSM=IDLE. Reset mid-transaction drops any pending ack; the host must retry.
- Address map (offsets from BASE_ADDR):
  - 0x0000–(4·2^AW−4): buffer window, word index = adr[AW+1:2].
  - 0x1000 CTRL (RW): bit0 enable; bit1 clr_ptr (self-clearing, reads 0); bit2 irq_ack (write-1-clear, reads 0).
  - 0x1004 STATUS (RO): [AW-1:0] wr_ptr, [16] wrap_flag, [31:24] frame_cnt.
  - Any other in-range address: ack, read data 0, writes ignored. Accesses outside the block are not decoded (no ack).
- Host request = cyc&stb&decoded. The request is only sampled in IDLE, so the ack cycle never re-triggers.
- FSM IDLE→MEM_RD→ACK for buffer reads: grant cycle drives mem_en=1, we=0. The next cycle captures mem_rdata_i into wbs_dat_o and asserts ack. Ack appears 2 cycles after grant.
- Buffer write: grant cycle drives mem_en=1, we=1, wmask=wbs_sel_i. Ack follows 1 cycle after grant (IDLE→ACK).
- Register access: ack 1 cycle after request. No SRAM use, so a stream write may proceed in the same cycle.
- SRAM arbitration, each cycle the FSM is in IDLE:
  - Stream wins if enable&s_valid_i and (no host buffer request or starve_cnt<STARVE_MAX).
  - Otherwise the host wins.
  - In MEM_RD/ACK the SRAM is free for the stream.
- s_ready_o is combinational: high exactly in a cycle where a stream write is issued.
- Stream write: mem_we=1, wmask=4'hF, addr=wr_ptr; wr_ptr increments.
- Wrap: at wr_ptr=2^AW−1 the pointer goes to 0, frame_cnt increments (8-bit, wraps 255→0) and wrap_flag sets.
- starve_cnt: increments on a stream grant while a host buffer request is pending; clears on a host grant or when no request is pending; saturates at STARVE_MAX.
- irq_o = wrap_flag.
  - irq_ack clears wrap_flag, but a wrap in the same cycle wins (flag stays 1).
  - clr_ptr zeroes wr_ptr and frame_cnt. It wins over a same-cycle increment; a stream write issued that cycle still lands at the old pointer.
- enable=0: s_ready_o=0. Pointers hold.

Decomposition:
- Package sonar_buf_pkg: CTRL/STATUS offsets, CTRL bit positions, FSM state enum, window-size constant.
- One sub-module is natural: sonar_buf_regs (CTRL/STATUS registers, pointer/frame counters, irq).
- Arbitration FSM and Wishbone decode stay in the top.

Test Plan:
- Reset then enable=1, stream 3 samples A0,A1,A2 with s_valid held; no host traffic → s_ready_o high 3 consecutive cycles; SRAM addresses 0,1,2; STATUS reads wr_ptr=3.
- Host read of word 1 while stream idle → mem_en at grant, ack exactly 2 cycles later, wbs_dat_o=A1.
- Stream valid continuously with a host read pending, STARVE_MAX=4 → exactly 4 stream grants, then 1 host grant (s_ready_o=0 that cycle), then streaming resumes.
- Stream 2^AW+1 samples → wr_ptr returns to 1, frame_cnt=1, irq_o=1. Write CTRL bit2 → irq_o=0. Repeat with the ack coinciding with a wrap → irq_o stays 1.
- Write CTRL clr_ptr in the same cycle as a stream write at ptr=5 → SRAM written at 5; wr_ptr=0 next cycle; frame_cnt=0.
- Assert wb_rst_n low during MEM_RD → wbs_ack_o never pulses, outputs 0 immediately. After release, a host write with sel=4'b0011 to word 7 → mem_wmask_o=4'b0011, ack 1 cycle after grant.
